// File: rtl/fp_add_seq.sv
// fp_add_seq
//   Multi-cycle binary16 adder sequencer. Drives an external 11-bit
//   significand adder through ALIGN -> ADD -> NORM and returns a packed,
//   truncated sum. Subnormal inputs are treated as zero; the outcome for
//   Inf/NaN/zero operands is decided up front.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, sampled only while idle
//   a, b          : binary16 operands
//   busy          : high from the accepting edge until the edge leaving DONE
//   done          : one-cycle pulse, result valid
//   result        : sum, held until the next operation retires
//   add_a, add_b  : adder operands (zero outside the ADD state)
//   add_kin       : adder carry-in, 2'b00 kill / 2'b11 generate
//   add_sum       : adder result {carry, sum[10:0]}, combinational
module fp_add_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [10:0] add_a,
    output logic [10:0] add_b,
    output logic [1:0]  add_kin,
    input  logic [11:0] add_sum
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state;
    logic        sign_r;     // sign of the larger-magnitude operand
    logic        sub_r;      // effective subtract
    logic [4:0]  exp_r;
    logic [10:0] l_sig;
    logic [10:0] s_sig;
    logic [10:0] sig;
    logic [3:0]  cnt;
    logic        fin;        // result already known; NORM only retires it
    logic [15:0] fin_val;

    // Operand decode used while idle
    logic        a_zero, b_zero, a_spec, b_spec, a_nan, b_nan, special;
    logic        a_ge_b;
    logic [15:0] l_op;
    logic [14:0] s_op;
    logic [4:0]  exp_diff;
    logic [3:0]  shamt;
    logic [15:0] spec_res;

    always_comb begin
        a_zero   = (a[14:10] == 5'd0);
        b_zero   = (b[14:10] == 5'd0);
        a_spec   = (a[14:10] == 5'd31);
        b_spec   = (b[14:10] == 5'd31);
        a_nan    = a_spec && (a[9:0] != 10'd0);
        b_nan    = b_spec && (b[9:0] != 10'd0);
        special  = a_zero | b_zero | a_spec | b_spec;

        a_ge_b   = (a[14:0] >= b[14:0]);
        l_op     = a_ge_b ? a : b;
        s_op     = a_ge_b ? b[14:0] : a[14:0];
        exp_diff = l_op[14:10] - s_op[14:10];
        // Beyond 12 places the smaller significand is gone anyway
        shamt    = (exp_diff > 5'd12) ? 4'd12 : exp_diff[3:0];

        if (a_nan || b_nan)
            spec_res = 16'h7E00;
        else if (a_spec && b_spec)
            spec_res = (a[15] == b[15]) ? a : 16'h7E00;
        else if (a_spec)
            spec_res = a;
        else if (b_spec)
            spec_res = b;
        else if (a_zero && b_zero)
            spec_res = 16'h0000;
        else if (a_zero)
            spec_res = b;
        else
            spec_res = a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 16'h0000;
            add_a   <= 11'd0;
            add_b   <= 11'd0;
            add_kin <= 2'b00;
            sign_r  <= 1'b0;
            sub_r   <= 1'b0;
            exp_r   <= 5'd0;
            l_sig   <= 11'd0;
            s_sig   <= 11'd0;
            sig     <= 11'd0;
            cnt     <= 4'd0;
            fin     <= 1'b0;
            fin_val <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (special) begin
                            // Early exits retire through NORM so every
                            // path leaves from the same state.
                            fin     <= 1'b1;
                            fin_val <= spec_res;
                            state   <= NORM;
                        end else begin
                            fin    <= 1'b0;
                            sign_r <= l_op[15];
                            sub_r  <= a[15] ^ b[15];
                            exp_r  <= l_op[14:10];
                            l_sig  <= {1'b1, l_op[9:0]};
                            s_sig  <= {1'b1, s_op[9:0]};
                            cnt    <= shamt;
                            state  <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    if (cnt != 4'd0) begin
                        s_sig <= s_sig >> 1;
                        cnt   <= cnt - 4'd1;
                    end else begin
                        // Adder operands are registered on entry to ADD
                        add_a   <= l_sig;
                        add_b   <= sub_r ? ~s_sig : s_sig;
                        add_kin <= sub_r ? 2'b11 : 2'b00;
                        state   <= ADD;
                    end
                end

                ADD: begin
                    add_a   <= 11'd0;
                    add_b   <= 11'd0;
                    add_kin <= 2'b00;
                    state   <= NORM;
                    if (!sub_r && add_sum[11]) begin
                        if (exp_r == 5'd30) begin
                            fin     <= 1'b1;
                            fin_val <= {sign_r, 15'h7C00};
                        end else begin
                            exp_r <= exp_r + 5'd1;
                            sig   <= add_sum[11:1];
                        end
                    end else if (sub_r && (add_sum[10:0] == 11'd0)) begin
                        // Exact cancellation is always +0
                        fin     <= 1'b1;
                        fin_val <= 16'h0000;
                    end else begin
                        // Subtract: add_sum[11] is the borrow complement
                        sig <= add_sum[10:0];
                    end
                end

                NORM: begin
                    if (fin) begin
                        result <= fin_val;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (sig[10]) begin
                        result <= {sign_r, exp_r, sig[9:0]};
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (exp_r == 5'd1) begin
                        // Next shift would go subnormal: flush
                        result <= {sign_r, 15'h0000};
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        sig   <= sig << 1;
                        exp_r <= exp_r - 5'd1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    fin   <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq
//   Table of directed vectors, hand sequences for start-while-busy and
//   reset mid-operation, and random operands checked against a
//   loop-based reference model of the addition rules.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] result;
    logic [10:0] add_a, add_b;
    logic [1:0]  add_kin;
    logic [11:0] add_sum;

    int errors = 0;
    int checks = 0;

    // Snapshot of adder activity during the last operation
    logic [10:0] sn_a, sn_b;
    logic [1:0]  sn_k;
    int          sn_cyc, sn_n;

    fp_add_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .add_a(add_a), .add_b(add_b), .add_kin(add_kin), .add_sum(add_sum)
    );

    always #5 clk = ~clk;

    // Shared significand adder
    assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {11'd0, (add_kin == 2'b11)};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: result and latency (edges from accept to DONE entry)
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output int lat);
        int ex, ey, e, d, sh, ml, ms, m, n;
        logic sl;
        logic [15:0] lo, so;
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        lat = 1;
        if ((ex == 31 && x[9:0] != 0) || (ey == 31 && y[9:0] != 0)) begin r = 16'h7E00; return; end
        if (ex == 31 && ey == 31) begin r = (x[15] == y[15]) ? x : 16'h7E00; return; end
        if (ex == 31) begin r = x; return; end
        if (ey == 31) begin r = y; return; end
        if (ex == 0 && ey == 0) begin r = 16'h0000; return; end
        if (ex == 0) begin r = y; return; end
        if (ey == 0) begin r = x; return; end
        if (x[14:0] >= y[14:0]) begin lo = x; so = y; end else begin lo = y; so = x; end
        sl = lo[15];
        e  = int'(lo[14:10]);
        d  = e - int'(so[14:10]);
        sh = (d > 12) ? 12 : d;
        ml = 1024 + int'(lo[9:0]);
        ms = (1024 + int'(so[9:0])) >> sh;
        lat = sh + 3;
        if (x[15] == y[15]) begin
            m = ml + ms;
            if (m >= 2048) begin
                m = m / 2;
                e = e + 1;
                if (e >= 31) begin r = {sl, 15'h7C00}; return; end
            end
            r = {sl, 5'(e), 10'(m)};
            return;
        end
        m = ml - ms;
        if (m == 0) begin r = 16'h0000; return; end
        n = 0;
        while (m < 1024) begin
            if (e == 1) begin r = {sl, 15'h0000}; lat = lat + n; return; end
            m = m * 2;
            e = e - 1;
            n++;
        end
        r = {sl, 5'(e), 10'(m)};
        lat = lat + n;
    endfunction

    // Run one operation; returns result at done and latency in edges
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                          input logic [15:0] exp_res,
                          output logic [15:0] res, output int lat);
        lat = -1;
        res = 16'h0;
        sn_n = 0; sn_cyc = 0; sn_a = 0; sn_b = 0; sn_k = 0;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", busy, 1);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (add_a != 0 || add_b != 0 || add_kin != 0) begin
                sn_n++; sn_cyc = k; sn_a = add_a; sn_b = add_b; sn_k = add_kin;
            end
            if (done) begin lat = k; res = result; break; end
        end
        chk("done_seen", done, 1);
        @(posedge clk); #1;
        chk("busy_fall", busy, 0);
        chk("done_pulse", done, 0);
        chk("result_hold", result, exp_res);
    endtask

    typedef struct {
        logic [15:0] a, b, res;
        int          lat;
        bit          ck;
        logic [10:0] xa, xb;
        logic [1:0]  xk;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [15:0] res, mres, ra, rb;
        logic [15:0] sp[6];
        int lat, mlat, mode, r, e, dcnt;

        vecs[0]  = '{16'h3C00, 16'h3C00, 16'h4000, 3,  1'b1, 11'h400, 11'h400, 2'b00};
        vecs[1]  = '{16'h3C00, 16'h3800, 16'h3E00, 4,  1'b1, 11'h400, 11'h200, 2'b00};
        vecs[2]  = '{16'h3C00, 16'hBA00, 16'h3400, 6,  1'b1, 11'h400, 11'h4FF, 2'b11};
        vecs[3]  = '{16'h3C00, 16'hBC00, 16'h0000, 3,  1'b1, 11'h400, 11'h3FF, 2'b11};
        vecs[4]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 3,  1'b1, 11'h7FF, 11'h7FF, 2'b00};
        vecs[5]  = '{16'h7C00, 16'hFC00, 16'h7E00, 1,  1'b0, 11'h0,   11'h0,   2'b00};
        vecs[6]  = '{16'h0400, 16'h8000, 16'h0400, 1,  1'b0, 11'h0,   11'h0,   2'b00};
        vecs[7]  = '{16'h0401, 16'h8400, 16'h0000, 3,  1'b0, 11'h0,   11'h0,   2'b00};
        vecs[8]  = '{16'h8401, 16'h0400, 16'h8000, 3,  1'b0, 11'h0,   11'h0,   2'b00};
        vecs[9]  = '{16'h7E00, 16'h3C00, 16'h7E00, 1,  1'b0, 11'h0,   11'h0,   2'b00};
        vecs[10] = '{16'h7C00, 16'h3C00, 16'h7C00, 1,  1'b0, 11'h0,   11'h0,   2'b00};
        vecs[11] = '{16'hFC00, 16'hFC00, 16'hFC00, 1,  1'b0, 11'h0,   11'h0,   2'b00};
        vecs[12] = '{16'h0000, 16'h8000, 16'h0000, 1,  1'b0, 11'h0,   11'h0,   2'b00};
        vecs[13] = '{16'h3C00, 16'h0000, 16'h3C00, 1,  1'b0, 11'h0,   11'h0,   2'b00};
        vecs[14] = '{16'h7800, 16'h0400, 16'h7800, 15, 1'b0, 11'h0,   11'h0,   2'b00};
        vecs[15] = '{16'h0800, 16'h87FF, 16'h0000, 5,  1'b0, 11'h0,   11'h0,   2'b00};

        sp[0] = 16'h0000; sp[1] = 16'h8000; sp[2] = 16'h7C00;
        sp[3] = 16'hFC00; sp[4] = 16'h7E01; sp[5] = 16'h03FF;

        rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 16'h0000);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_kin", add_kin, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_add_cycles", i), sn_n, (vecs[i].lat == 1) ? 0 : 1);
            if (vecs[i].ck) begin
                chk($sformatf("vec%0d_add_a", i), sn_a, vecs[i].xa);
                chk($sformatf("vec%0d_add_b", i), sn_b, vecs[i].xb);
                chk($sformatf("vec%0d_add_kin", i), sn_k, vecs[i].xk);
            end
        end

        // start held high with changing operands: only the first op runs
        @(negedge clk);
        a = 16'h3C00; b = 16'h3800; start = 1'b1;
        @(posedge clk); #1;
        lat = -1; res = 16'h0;
        for (int k = 1; k <= 30; k++) begin
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            if (done) begin lat = k; res = result; break; end
        end
        start = 1'b0;
        chk("held_start_result", res, 16'h3E00);
        chk("held_start_latency", lat, 4);
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("held_start_single_done", dcnt, 0);
        chk("held_start_idle", busy, 0);

        // Reset while normalizing
        @(negedge clk);
        a = 16'h3C00; b = 16'hBA00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 16'h0000);
        chk("mid_rst_add_a", add_a, 0);
        chk("mid_rst_add_b", add_b, 0);
        chk("mid_rst_add_kin", add_kin, 0);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        chk("post_rst_quiet", dcnt, 0);
        run_op(16'h3C00, 16'hBA00, 16'h3400, res, lat);
        chk("post_rst_result", res, 16'h3400);
        chk("post_rst_latency", lat, 6);

        // Random operands against the reference model
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            mode = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 6));
            case (mode)
                0: rb = 16'($urandom);
                1: rb = {1'($urandom), ra[14:10], 10'($urandom)};
                2: begin
                    e = int'(ra[14:10]) + r - 3;
                    if (e < 0) e = 0;
                    if (e > 31) e = 31;
                    rb = {1'($urandom), 5'(e), 10'($urandom)};
                end
                default: rb = sp[$urandom_range(0, 5)];
            endcase
            model(ra, rb, mres, mlat);
            run_op(ra, rb, mres, res, lat);
            if (res !== mres || lat != mlat)
                $display("  operands %h + %h", ra, rb);
            chk("rand_result", res, mres);
            chk("rand_latency", lat, mlat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
